mem_lsu_bridge: RTL and testbench

MEM_LSU_BRIDGE -- requirements
Module: mem_lsu_bridge

---
 rtl/mem_lsu_bridge.sv | 158 +++++++++++++++
 tb/tb_mem_lsu_bridge.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_bridge.sv
// rtl/mem_lsu_bridge.sv - CPU load/store to word-wide memory data port bridge
// Optional MEM_LSU_UNALIGNED_TRAP_EN: misaligned half/word requests return resp_err without a memory access.
module mem_lsu_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dp_address,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  output logic        read_dp,
  output logic        write_dp,
  input  logic [31:0] dp_readdata,
  input  logic        stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        write_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  lane;
  logic [3:0]  be_c;
  logic [31:0] rd_shift, load_ext;

`ifdef MEM_LSU_UNALIGNED_TRAP_EN
  logic req_misaligned;
  logic err_q;
  assign req_misaligned = ((req_size == 2'b01) && req_address[0]) ||
                          (req_size[1] && (req_address[1:0] != 2'b00));
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign resp_rdata = rdata_q;

  // Lane offset ignores address bits below the access size, so untrapped
  // misaligned accesses behave as if those bits were zero.
  always_comb begin
    lane = 2'b00;
    be_c = 4'b1111;
    case (size_q)
      2'b00: begin
        lane = addr_q[1:0];
        be_c = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        lane = {addr_q[1], 1'b0};
        be_c = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: begin
        lane = 2'b00;
        be_c = 4'b1111;
      end
    endcase
  end

  always_comb begin
    rd_shift = dp_readdata >> {lane, 3'b000};
    load_ext = rd_shift;
    case (size_q)
      2'b00:   load_ext = signed_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                   : {24'h0, rd_shift[7:0]};
      2'b01:   load_ext = signed_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                   : {16'h0, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
`ifdef MEM_LSU_UNALIGNED_TRAP_EN
          state_next = req_misaligned ? RESP : ACCESS;
`else
          state_next = ACCESS;
`endif
        end
      end
      ACCESS:  if (!stall) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dp_address = 32'h0;
    byteenable = 4'h0;
    writedata  = 32'h0;
    read_dp    = 1'b0;
    write_dp   = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        dp_address = {addr_q[31:2], 2'b00};
        byteenable = be_c;
        writedata  = wdata_q << {lane, 3'b000};
        read_dp    = ~write_q;
        write_dp   = write_q;
      end
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
`ifdef MEM_LSU_UNALIGNED_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= req_address;
            wdata_q  <= req_wdata;
            rdata_q  <= 32'h0;
`ifdef MEM_LSU_UNALIGNED_TRAP_EN
            err_q    <= req_misaligned;
`endif
          end
        end
        ACCESS: if (!stall) rdata_q <= write_q ? 32'h0 : load_ext;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu_bridge.sv
// tb/tb_mem_lsu_bridge.sv - directed self-checking bench for mem_lsu_bridge
module tb_mem_lsu_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_address = 32'h0, req_wdata = 32'h0;
  logic        resp_valid, resp_ready = 1'b1, resp_err;
  logic [31:0] resp_rdata, dp_address, writedata, dp_readdata;
  logic [3:0]  byteenable;
  logic        read_dp, write_dp, stall = 1'b0;

  logic [31:0] mem [0:7];
  logic [31:0] lane_mask;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  always #5 clk = ~clk;

  mem_lsu_bridge dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .dp_address(dp_address), .writedata(writedata), .byteenable(byteenable),
    .read_dp(read_dp), .write_dp(write_dp), .dp_readdata(dp_readdata),
    .stall(stall)
  );

  assign lane_mask   = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign dp_readdata = read_dp ? (mem[dp_address[4:2]] & lane_mask) : 32'h0;

  always @(posedge clk) begin
    if (write_dp && !stall)
      mem[dp_address[4:2]] <= (mem[dp_address[4:2]] & ~lane_mask) | (writedata & lane_mask);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Unstalled transaction: accept, one ACCESS cycle, one RESP cycle consumed at once.
  task automatic do_access(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] exp_be, input logic [31:0] exp_dpa,
                           input logic [31:0] exp_wr, input logic [31:0] exp_rd);
    req_write = w; req_size = sz; req_signed = sg; req_address = addr; req_wdata = wd;
    req_valid = 1'b1;
    check("accept_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("acc_dp_address", dp_address, exp_dpa);
    check("acc_byteenable", byteenable, exp_be);
    check("acc_read_dp", read_dp, !w);
    check("acc_write_dp", write_dp, w);
    if (w) check("acc_writedata", writedata, exp_wr);
    check("acc_no_resp", resp_valid, 0);
    step();
    check("resp_valid", resp_valid, 1);
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", resp_err, 0);
    check("resp_strobes", {read_dp, write_dp}, 0);
    step();
    check("back_idle", req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;
    step();
    step();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_strobes", {read_dp, write_dp}, 0);
    check("rst_byteenable", byteenable, 0);
    check("rst_dp_address", dp_address, 0);
    check("rst_writedata", writedata, 0);
    check("rst_rdata", resp_rdata, 0);
    rst = 1'b0;
    step();

    do_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 4'b1000, 32'h10, 32'h0, 32'hFFFFFF88);
    do_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 4'b1100, 32'h10, 32'h0, 32'h00008899);
    do_access(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 4'b0001, 32'h10, 32'h0, 32'hFFFFFFBB);
    do_access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 4'b0011, 32'h10, 32'h0, 32'hFFFFAABB);

`ifdef MEM_LSU_UNALIGNED_TRAP_EN
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_address = 32'h12;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("trap_no_read", read_dp, 0);
    check("trap_resp_valid", resp_valid, 1);
    check("trap_resp_err", resp_err, 1);
    check("trap_rdata", resp_rdata, 0);
    step();
    check("trap_back_idle", req_ready, 1);
`else
    do_access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 4'b1111, 32'h10, 32'h0, 32'h8899AABB);
`endif

    do_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CD, 4'b0010, 32'h10, 32'h0000CD00, 32'h0);
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 4'b1111, 32'h10, 32'h0, 32'h8899CDBB);
    do_access(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF1234, 4'b1100, 32'h14, 32'h12340000, 32'h0);
    do_access(1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 4'b1111, 32'h14, 32'h0, 32'h12340000);

    // Stalled word load with a slow consumer.
    req_write = 1'b0; req_size = 2'b10; req_address = 32'h10; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    stall = 1'b1;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_read_dp", read_dp, 1);
      check("stall_dp_address", dp_address, 32'h10);
      check("stall_byteenable", byteenable, 4'b1111);
      check("stall_no_resp", resp_valid, 0);
      check("stall_not_ready", req_ready, 0);
      step();
    end
    stall = 1'b0;
    check("stall_last_read_dp", read_dp, 1);
    step();
    for (int i = 0; i < 2; i++) begin
      check("hold_resp_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, 32'h8899CDBB);
      check("hold_not_ready", req_ready, 0);
      check("hold_strobes", {read_dp, write_dp}, 0);
      step();
    end
    resp_ready = 1'b1;
    check("hold_release", resp_valid, 1);
    step();
    check("stall_done_idle", req_ready, 1);
    check("stall_done_no_resp", resp_valid, 0);

    // Reset while stalled in ACCESS abandons the request.
    req_address = 32'h10; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    stall = 1'b1;
    check("abort_in_access", read_dp, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    stall = 1'b0;
    check("abort_req_ready", req_ready, 1);
    check("abort_strobes", {read_dp, write_dp}, 0);
    check("abort_byteenable", byteenable, 0);
    check("abort_rdata", resp_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_resp", resp_valid, 0);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
